systolic_array_feeder: RTL and testbench
========================================

Name: systolic_array_feeder

Overview:
- Edge driver for a ROWS x COLS grid of output/weight-stationary PEs.
- Loads one weight tile through the top edge, then streams activation vectors into the left edge with diagonal skew (row r delayed r cycles). It then waits for the wavefront to flush and pulses done.
- Sits between the tile buffers (valid/ready sources) and the array's top/left boundary ports.

Parameters:
ROWS, 4, array rows (left-edge lanes)
COLS, 4, array columns (top-edge lanes)
DATA_WIDTH, 8, weight/activation width
ACCU_DATA_WIDTH, 32, top-edge word width (weight zero-extended into it)
K_WIDTH, 16, width of the vector-count config

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle pulse, accepted only in IDLE
i_cfg_k  in  K_WIDTH  activation vectors to stream; sampled on accepted start; 0 treated as 1
i_w_data  in  COLS*DATA_WIDTH  one weight row, lane c in bits [c*DATA_WIDTH +: DATA_WIDTH]
i_w_valid  in  1  weight row valid
o_w_ready  out  1  weight row accepted when valid&ready
i_a_data  in  ROWS*DATA_WIDTH  one activation vector, lane r for array row r
i_a_valid  in  1  activation vector valid
o_a_ready  out  1  activation accepted when valid&ready
o_data_top  out  COLS*ACCU_DATA_WIDTH  top-edge data per column
o_valid_top  out  COLS  top-edge valid per column
o_cmd_top  out  COLS  top-edge load-weight command per column
o_data_left  out  ROWS*DATA_WIDTH  left-edge data per row
o_valid_left  out  ROWS  left-edge valid per row
o_cmd_left  out  ROWS  left-edge accumulate command per row
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at completion

Behaviour:
- All outputs are registered. On rst all outputs are 0, the FSM goes to IDLE, counters clear and the skew pipes clear. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, LOAD_W, STREAM, FLUSH, DONE.
- IDLE:
  - o_w_ready=0, o_a_ready=0.
  - On i_start: latch k (0 becomes 1) and go to LOAD_W.
  - i_start in any other state is ignored.
- LOAD_W:
  - o_w_ready=1 until ROWS rows have been accepted; a row counter runs 0..ROWS-1.
  - Each accepted row drives, on the next cycle, all COLS lanes: o_valid_top=all-ones, o_cmd_top=all-ones, o_data_top lane c = zero-extended weight.
  - A cycle with no accepted row drives valid/cmd/data top = 0 (bubble). The array's first-latch-wins rule means row i in order lands in PE row i, so bubbles are harmless.
  - After the ROWS-th accept, go to STREAM.
- STREAM:
  - o_a_ready=1 while the accepted count < k. Top edge is held at 0 (valid/cmd/data).
  - Each accepted vector enters skew stage 0.
  - Lane r output = lane r of the vector delayed by r cycles; lane 0 is registered once, lane r passes through r extra flops.
  - valid_left[r] and cmd_left[r] travel in the same pipe, set 1 for an accepted vector and 0 for a bubble.
  - Bubbles occur when i_a_valid=0 in STREAM; the pipe always shifts, with no backpressure on the array.
  - On the k-th accept, go to FLUSH.
- FLUSH:
  - Zeros are injected into stage 0.
  - A counter waits ROWS+COLS-1 cycles, so the last skewed vector reaches the far corner PE, then the FSM goes to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. Done and start in the same cycle: start is ignored.
- Latency: the first accepted activation appears on lane 0 one cycle after acceptance and on lane r r+1 cycles after acceptance.
- Widths: the weight is zero-extended to ACCU_DATA_WIDTH; no arithmetic is performed in this block.
- ready never depends combinationally on valid.
- Simultaneous i_w_valid in STREAM, or i_a_valid in LOAD_W, is not accepted (ready=0).

Test Plan:
- ROWS=COLS=4: start with k=3; supply weight rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} back-to-back. Required: top edge shows 4 consecutive all-ones valid/cmd cycles with those values; STREAM entered the cycle after the 4th accept.
- Activation vectors {1,1,1,1},{2,2,2,2},{3,3,3,3} with i_a_valid held high. Required: lane r carries 1,2,3 starting r+1 cycles after the first accept, and valid_left[r] is high for exactly 3 cycles.
- The same stream with i_a_valid low for 2 cycles between vectors 1 and 2. Required: a 2-cycle valid=0 gap appears on every lane, skewed by r.
- After the 3rd accept, done pulses exactly 7 cycles (ROWS+COLS-1) later plus 1 for the DONE state. o_busy drops the next cycle, and a 4th activation offered is not accepted.
- k=0: exactly 1 vector is accepted, then FLUSH and done. A second i_start while busy is ignored.
- Assert rst during STREAM. Required: next cycle all outputs 0, state IDLE, no done pulse; a fresh run then completes correctly.

Source files
------------

// File: rtl/systolic_array_feeder.sv
// Edge driver for a ROWS x COLS systolic array: loads one weight tile through the top
// edge, then streams diagonally skewed activation vectors into the left edge.
module systolic_array_feeder #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int ACCU_DATA_WIDTH = 32,
  parameter int K_WIDTH         = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [K_WIDTH-1:0]              i_cfg_k,
  input  logic [COLS*DATA_WIDTH-1:0]      i_w_data,
  input  logic                            i_w_valid,
  output logic                            o_w_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]      i_a_data,
  input  logic                            i_a_valid,
  output logic                            o_a_ready,
  output logic [COLS*ACCU_DATA_WIDTH-1:0] o_data_top,
  output logic [COLS-1:0]                 o_valid_top,
  output logic [COLS-1:0]                 o_cmd_top,
  output logic [ROWS*DATA_WIDTH-1:0]      o_data_left,
  output logic [ROWS-1:0]                 o_valid_left,
  output logic [ROWS-1:0]                 o_cmd_left,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int FLUSH_CYC = ROWS + COLS - 1;
  localparam int WCNT_W    = $clog2(ROWS + 1);
  localparam int FCNT_W    = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                       state_r;
  state_t                       next_state_s;
  logic [WCNT_W-1:0]            w_cnt_r;
  logic [K_WIDTH-1:0]           a_cnt_r;
  logic [K_WIDTH-1:0]           k_r;
  logic [FCNT_W-1:0]            f_cnt_r;
  logic                         w_ready_r;
  logic                         a_ready_r;
  logic                         busy_r;
  logic                         done_r;
  logic                         w_accept_s;
  logic                         a_accept_s;
  logic [COLS*ACCU_DATA_WIDTH-1:0] w_ext_s;
  logic [COLS*ACCU_DATA_WIDTH-1:0] top_data_r;
  logic                         top_vld_r;

  // Readies are registers, so acceptance never depends combinationally on valid.
  assign w_accept_s = i_w_valid & w_ready_r;
  assign a_accept_s = i_a_valid & a_ready_r;

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) next_state_s = ST_LOAD_W;
        else         next_state_s = ST_IDLE;
      end
      ST_LOAD_W: begin
        if (w_accept_s && (w_cnt_r == WCNT_W'(ROWS - 1))) next_state_s = ST_STREAM;
        else                                               next_state_s = ST_LOAD_W;
      end
      ST_STREAM: begin
        if (a_accept_s && (a_cnt_r == (k_r - K_WIDTH'(1)))) next_state_s = ST_FLUSH;
        else                                                  next_state_s = ST_STREAM;
      end
      ST_FLUSH: begin
        if (f_cnt_r == FCNT_W'(FLUSH_CYC - 1)) next_state_s = ST_DONE;
        else                                    next_state_s = ST_FLUSH;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, counters and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      w_cnt_r   <= '0;
      a_cnt_r   <= '0;
      k_r       <= '0;
      f_cnt_r   <= '0;
      w_ready_r <= 1'b0;
      a_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      w_ready_r <= (next_state_s == ST_LOAD_W);
      a_ready_r <= (next_state_s == ST_STREAM);
      busy_r    <= (next_state_s != ST_IDLE);
      done_r    <= (next_state_s == ST_DONE);
      if ((state_r == ST_IDLE) && i_start) begin
        k_r     <= (i_cfg_k == K_WIDTH'(0)) ? K_WIDTH'(1) : i_cfg_k;
        w_cnt_r <= '0;
        a_cnt_r <= '0;
        f_cnt_r <= '0;
      end else begin
        if (w_accept_s)            w_cnt_r <= w_cnt_r + WCNT_W'(1);
        if (a_accept_s)            a_cnt_r <= a_cnt_r + K_WIDTH'(1);
        if (state_r == ST_FLUSH)   f_cnt_r <= f_cnt_r + FCNT_W'(1);
      end
    end
  end

  // Zero-extend each weight lane to the top-edge word width.
  always_comb begin
    w_ext_s = '0;
    for (int c = 0; c < COLS; c++) begin
      w_ext_s[c*ACCU_DATA_WIDTH +: ACCU_DATA_WIDTH] =
        ACCU_DATA_WIDTH'(i_w_data[c*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Top edge: one weight row broadcast to all columns per accept, zeros otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_data_r <= '0;
      top_vld_r  <= 1'b0;
    end else if (w_accept_s) begin
      top_data_r <= w_ext_s;
      top_vld_r  <= 1'b1;
    end else begin
      top_data_r <= '0;
      top_vld_r  <= 1'b0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in_s;
    logic [DATA_WIDTH-1:0] dpipe_r [0:r];
    logic                  vpipe_r [0:r];

    assign lane_in_s = a_accept_s ? i_a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Lane r skew pipe: r+1 flops, always shifting, bubbles enter as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          dpipe_r[i] <= '0;
          vpipe_r[i] <= 1'b0;
        end
      end else begin
        dpipe_r[0] <= lane_in_s;
        vpipe_r[0] <= a_accept_s;
        for (int i = 1; i <= r; i++) begin
          dpipe_r[i] <= dpipe_r[i-1];
          vpipe_r[i] <= vpipe_r[i-1];
        end
      end
    end

    assign o_data_left[r*DATA_WIDTH +: DATA_WIDTH] = dpipe_r[r];
    assign o_valid_left[r]                         = vpipe_r[r];
    assign o_cmd_left[r]                           = vpipe_r[r];
  end

  assign o_w_ready   = w_ready_r;
  assign o_a_ready   = a_ready_r;
  assign o_data_top  = top_data_r;
  assign o_valid_top = {COLS{top_vld_r}};
  assign o_cmd_top   = {COLS{top_vld_r}};
  assign o_busy      = busy_r;
  assign o_done      = done_r;

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Directed self-checking bench for systolic_array_feeder (ROWS=COLS=4, 8-bit data,
// 32-bit top-edge words).
module tb_systolic_array_feeder;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [15:0]  i_cfg_k;
  logic [31:0]  i_w_data;
  logic         i_w_valid;
  logic         o_w_ready;
  logic [31:0]  i_a_data;
  logic         i_a_valid;
  logic         o_a_ready;
  logic [127:0] o_data_top;
  logic [3:0]   o_valid_top;
  logic [3:0]   o_cmd_top;
  logic [31:0]  o_data_left;
  logic [3:0]   o_valid_left;
  logic [3:0]   o_cmd_left;
  logic         o_busy;
  logic         o_done;

  int tests_run    = 0;
  int tests_failed = 0;

  systolic_array_feeder #(
    .ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACCU_DATA_WIDTH(32), .K_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_k(i_cfg_k),
    .i_w_data(i_w_data), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready),
    .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
    .o_data_top(o_data_top), .o_valid_top(o_valid_top), .o_cmd_top(o_cmd_top),
    .o_data_left(o_data_left), .o_valid_left(o_valid_left), .o_cmd_left(o_cmd_left),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] k);
    i_start = 1'b1;
    i_cfg_k = k;
    tick();
    i_start = 1'b0;
    check("start_busy",    128'(o_busy),    128'(1));
    check("start_w_ready", 128'(o_w_ready), 128'(1));
    check("start_a_ready", 128'(o_a_ready), 128'(0));
  endtask

  // Four weight rows; row j lane c carries 4j+c+1. Optional bubble before row 2.
  task automatic load_weights(input bit bubble);
    logic [31:0]  wd;
    logic [127:0] exp_top;
    i_a_valid = 1'b1;
    i_a_data  = 32'hFFFF_FFFF;
    for (int j = 0; j < 4; j++) begin
      if (bubble && (j == 2)) begin
        i_w_valid = 1'b0;
        tick();
        check("w_bubble_vld",  128'(o_valid_top), 128'(0));
        check("w_bubble_data", o_data_top,        128'(0));
        check("w_bubble_rdy",  128'(o_w_ready),   128'(1));
      end
      for (int c = 0; c < 4; c++) begin
        wd[c*8 +: 8]       = 8'(4*j + c + 1);
        exp_top[c*32 +: 32] = 32'(4*j + c + 1);
      end
      i_w_data  = wd;
      i_w_valid = 1'b1;
      tick();
      check("w_vld_top",  128'(o_valid_top),  128'(4'hF));
      check("w_cmd_top",  128'(o_cmd_top),    128'(4'hF));
      check("w_data_top", o_data_top,         exp_top);
      check("w_a_ready",  128'(o_a_ready),    128'(j == 3));
      check("w_w_ready",  128'(o_w_ready),    128'(j != 3));
      check("w_no_left",  128'(o_valid_left), 128'(0));
    end
    // Keep offering a weight row during STREAM; it must not be taken.
    i_w_data  = 32'hA5A5_A5A5;
    i_w_valid = 1'b1;
  endtask

  // Stream vectors; lane r of vector v carries v + ofs*r. Expected skew is built from
  // the bench's own acceptance schedule (ready expected while accepted < k).
  task automatic run_stream(input int k_eff, input bit gap, input bit poke_start);
    int          cnt;
    int          acc_edge;
    int          ofs;
    logic        v;
    logic        ha [0:15];
    logic [7:0]  hv [0:15];
    int          nvld [0:3];
    logic [31:0] exp_dl;
    logic [3:0]  exp_vl;
    cnt      = 0;
    acc_edge = -1;
    ofs      = gap ? 16 : 0;
    for (int r = 0; r < 4; r++) nvld[r] = 0;
    for (int n = 0; n < 16; n++) begin
      v = !(gap && ((n == 1) || (n == 2)));
      i_a_valid = v;
      for (int r = 0; r < 4; r++) i_a_data[r*8 +: 8] = 8'(cnt + 1 + ofs*r);
      i_start = poke_start && ((n == 1) || ((acc_edge >= 0) && (n == acc_edge + 8)));
      i_cfg_k = 16'd5;
      ha[n] = v && (cnt < k_eff);
      hv[n] = ha[n] ? 8'(cnt + 1) : 8'd0;
      if (ha[n]) begin
        cnt++;
        if (cnt == k_eff) acc_edge = n;
      end
      tick();
      i_start = 1'b0;
      exp_dl = 32'd0;
      exp_vl = 4'd0;
      for (int r = 0; r < 4; r++) begin
        if ((n - r >= 0) && ha[n-r]) begin
          exp_vl[r]        = 1'b1;
          exp_dl[r*8 +: 8] = 8'(hv[n-r] + 8'(ofs*r));
        end
        nvld[r] += int'(o_valid_left[r]);
      end
      check("s_data_left",  128'(o_data_left),  128'(exp_dl));
      check("s_valid_left", 128'(o_valid_left), 128'(exp_vl));
      check("s_cmd_left",   128'(o_cmd_left),   128'(exp_vl));
      check("s_a_ready",    128'(o_a_ready),    128'(cnt < k_eff));
      check("s_w_ready",    128'(o_w_ready),    128'(0));
      check("s_top_vld",    128'(o_valid_top),  128'(0));
      check("s_top_data",   o_data_top,         128'(0));
      check("s_done", 128'(o_done), 128'((acc_edge >= 0) && (n == acc_edge + 7)));
      check("s_busy", 128'(o_busy), 128'((acc_edge < 0) || (n <= acc_edge + 7)));
    end
    for (int r = 0; r < 4; r++) check("s_lane_count", 128'(nvld[r]), 128'(k_eff));
    i_a_valid = 1'b0;
    i_w_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_cfg_k   = 16'd0;
    i_w_data  = 32'd0;
    i_w_valid = 1'b0;
    i_a_data  = 32'd0;
    i_a_valid = 1'b0;
    tick();
    tick();
    check("rst_top", o_data_top, 128'(0));
    check("rst_rest", 128'({o_w_ready, o_a_ready, o_valid_top, o_cmd_top, o_data_left,
                            o_valid_left, o_cmd_left, o_busy, o_done}), 128'(0));
    rst = 1'b0;
    tick();
    check("idle_busy", 128'(o_busy), 128'(0));

    // k=3, continuous stream, back-to-back weights
    start_run(16'd3);
    load_weights(1'b0);
    run_stream(3, 1'b0, 1'b0);

    // k=3, weight bubble, 2-cycle activation gap after vector 1
    start_run(16'd3);
    load_weights(1'b1);
    run_stream(3, 1'b1, 1'b0);

    // k=0 behaves as 1; starts while busy and during DONE are ignored
    start_run(16'd0);
    load_weights(1'b0);
    run_stream(1, 1'b0, 1'b1);

    // Reset during STREAM aborts without done
    start_run(16'd3);
    load_weights(1'b0);
    i_w_valid = 1'b0;
    i_a_valid = 1'b1;
    i_a_data  = 32'h0101_0101;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    i_a_valid = 1'b0;
    check("mid_rst_top", o_data_top, 128'(0));
    check("mid_rst_rest", 128'({o_w_ready, o_a_ready, o_valid_top, o_cmd_top, o_data_left,
                                o_valid_left, o_cmd_left, o_busy, o_done}), 128'(0));
    for (int n = 0; n < 10; n++) begin
      tick();
      check("post_rst_done", 128'(o_done),       128'(0));
      check("post_rst_busy", 128'(o_busy),       128'(0));
      check("post_rst_left", 128'(o_valid_left), 128'(0));
    end

    // Fresh run after the abort
    start_run(16'd3);
    load_weights(1'b0);
    run_stream(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
